watch_timekeeper: RTL and testbench

- Time-of-day counter at the receiving end of the crystal divider's slow clock output.
- Runs on the 32.768 kHz crystal clock. Samples the divider's 0.5 Hz square wave as a plain data input; every edge (rising or falling) counts as one elapsed second.
- Keeps BCD hours/minutes/seconds for the display path and supports a manual set mode.

---
 rtl/watch_timekeeper.sv | 136 +++++++++++++
 tb/tb_watch_timekeeper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_timekeeper.sv
// BCD time-of-day counter clocked by the crystal; each edge of the divider's
// 0.5 Hz output is one second. Supports a manual set mode for hours/minutes.
module watch_timekeeper #(
    parameter bit FORMAT_24H = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       set_en_i,
    input  logic       set_min_i,
    input  logic       set_hour_i,
    output logic       sec_pulse_o,
    output logic [2:0] sec_t_o,
    output logic [3:0] sec_u_o,
    output logic [2:0] min_t_o,
    output logic [3:0] min_u_o,
    output logic [1:0] hr_t_o,
    output logic [3:0] hr_u_o
);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    // 12h mode has no hour zero, so it powers up at 12:00:00
    localparam logic [1:0] HR_T_RST = FORMAT_24H ? 2'd0 : 2'd1;
    localparam logic [3:0] HR_U_RST = FORMAT_24H ? 4'd0 : 4'd2;

    logic [0:0] state_reg, state_next;
    logic       tick_q, set_min_q, set_hour_q;
    logic       sec_pulse_reg, sec_pulse_next;
    logic [2:0] sec_t_reg, sec_t_next;
    logic [3:0] sec_u_reg, sec_u_next;
    logic [2:0] min_t_reg, min_t_next;
    logic [3:0] min_u_reg, min_u_next;
    logic [1:0] hr_t_reg, hr_t_next;
    logic [3:0] hr_u_reg, hr_u_next;

    logic tick_evt, set_min_evt, set_hour_evt;

    assign tick_evt     = tick_i ^ tick_q;
    assign set_min_evt  = set_min_i & ~set_min_q;
    assign set_hour_evt = set_hour_i & ~set_hour_q;

    function automatic logic [6:0] inc_base60(input logic [2:0] t, input logic [3:0] u);
        if (u != 4'd9)
            return {t, u + 4'd1};
        else if (t != 3'd5)
            return {t + 3'd1, 4'd0};
        return 7'd0;
    endfunction

    function automatic logic [5:0] inc_hour(input logic [1:0] t, input logic [3:0] u);
        if (FORMAT_24H) begin
            if (t == 2'd2 && u == 4'd3)
                return 6'd0;
        end else begin
            if (t == 2'd1 && u == 4'd2)
                return {2'd0, 4'd1};
        end
        if (u == 4'd9)
            return {t + 2'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    always_comb begin
        state_next     = state_reg;
        sec_pulse_next = 1'b0;
        sec_t_next     = sec_t_reg;
        sec_u_next     = sec_u_reg;
        min_t_next     = min_t_reg;
        min_u_next     = min_u_reg;
        hr_t_next      = hr_t_reg;
        hr_u_next      = hr_u_reg;

        case (state_reg)
            ST_RUN:  if (set_en_i)  state_next = ST_SET;
            default: if (!set_en_i) state_next = ST_RUN;
        endcase

        // Behaviour follows the state being entered: a set request beats a
        // coincident tick, and a tick in the exit cycle still counts.
        if (state_next == ST_SET) begin
            sec_t_next = 3'd0;
            sec_u_next = 4'd0;
            if (set_min_evt)
                {min_t_next, min_u_next} = inc_base60(min_t_reg, min_u_reg);
            if (set_hour_evt)
                {hr_t_next, hr_u_next} = inc_hour(hr_t_reg, hr_u_reg);
        end else if (tick_evt) begin
            sec_pulse_next = 1'b1;
            {sec_t_next, sec_u_next} = inc_base60(sec_t_reg, sec_u_reg);
            if (sec_t_reg == 3'd5 && sec_u_reg == 4'd9) begin
                {min_t_next, min_u_next} = inc_base60(min_t_reg, min_u_reg);
                if (min_t_reg == 3'd5 && min_u_reg == 4'd9)
                    {hr_t_next, hr_u_next} = inc_hour(hr_t_reg, hr_u_reg);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_RUN;
            tick_q        <= 1'b1;
            set_min_q     <= 1'b0;
            set_hour_q    <= 1'b0;
            sec_pulse_reg <= 1'b0;
            sec_t_reg     <= 3'd0;
            sec_u_reg     <= 4'd0;
            min_t_reg     <= 3'd0;
            min_u_reg     <= 4'd0;
            hr_t_reg      <= HR_T_RST;
            hr_u_reg      <= HR_U_RST;
        end else begin
            state_reg     <= state_next;
            tick_q        <= tick_i;
            set_min_q     <= set_min_i;
            set_hour_q    <= set_hour_i;
            sec_pulse_reg <= sec_pulse_next;
            sec_t_reg     <= sec_t_next;
            sec_u_reg     <= sec_u_next;
            min_t_reg     <= min_t_next;
            min_u_reg     <= min_u_next;
            hr_t_reg      <= hr_t_next;
            hr_u_reg      <= hr_u_next;
        end
    end

    assign sec_pulse_o = sec_pulse_reg;
    assign sec_t_o     = sec_t_reg;
    assign sec_u_o     = sec_u_reg;
    assign min_t_o     = min_t_reg;
    assign min_u_o     = min_u_reg;
    assign hr_t_o      = hr_t_reg;
    assign hr_u_o      = hr_u_reg;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Scoreboard bench: drives 24h and 12h instances with the same stimulus and
// checks both against an integer hours/minutes/seconds reference every cycle.
module tb_watch_timekeeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, tick = 1'b1, set_en = 1'b0, set_min = 1'b0, set_hour = 1'b0;

    logic       p24, p12;
    logic [2:0] st24, st12, mt24, mt12;
    logic [3:0] su24, su12, mu24, mu12, hu24, hu12;
    logic [1:0] ht24, ht12;

    watch_timekeeper #(.FORMAT_24H(1'b1)) dut24 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .set_en_i(set_en),
        .set_min_i(set_min), .set_hour_i(set_hour), .sec_pulse_o(p24),
        .sec_t_o(st24), .sec_u_o(su24), .min_t_o(mt24), .min_u_o(mu24),
        .hr_t_o(ht24), .hr_u_o(hu24)
    );

    watch_timekeeper #(.FORMAT_24H(1'b0)) dut12 (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .set_en_i(set_en),
        .set_min_i(set_min), .set_hour_i(set_hour), .sec_pulse_o(p12),
        .sec_t_o(st12), .sec_u_o(su12), .min_t_o(mt12), .min_u_o(mu12),
        .hr_t_o(ht12), .hr_u_o(hu12)
    );

    typedef struct packed {
        logic [20:0] e24;
        logic [20:0] e12;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    // Reference model: index 0 = 24h instance, 1 = 12h instance
    int mh[2], mm[2], ms[2];
    bit prev_tick = 1'b1, prev_min = 1'b0, prev_hr = 1'b0;

    function automatic int next_hour(int h, int f);
        if (f == 0) return (h + 1) % 24;
        return (h % 12) + 1;
    endfunction

    function automatic logic [20:0] pack_time(bit pulse, int h, int m, int s);
        return {pulse, 3'(s / 10), 4'(s % 10), 3'(m / 10), 4'(m % 10),
                2'(h / 10), 4'(h % 10)};
    endfunction

    // Predict the state after the coming edge, queue it, advance one cycle
    task automatic step();
        bit   pulse, tick_e, min_e, hr_e;
        exp_t e;
        pulse = 1'b0;
        if (rst) begin
            for (int f = 0; f < 2; f++) begin
                mh[f] = (f == 0) ? 0 : 12;
                mm[f] = 0;
                ms[f] = 0;
            end
            prev_tick = 1'b1;
            prev_min  = 1'b0;
            prev_hr   = 1'b0;
        end else begin
            tick_e = (tick != prev_tick);
            min_e  = set_min && !prev_min;
            hr_e   = set_hour && !prev_hr;
            for (int f = 0; f < 2; f++) begin
                if (set_en) begin
                    ms[f] = 0;
                    if (min_e) mm[f] = (mm[f] + 1) % 60;
                    if (hr_e)  mh[f] = next_hour(mh[f], f);
                end else if (tick_e) begin
                    ms[f]++;
                    if (ms[f] == 60) begin
                        ms[f] = 0;
                        mm[f]++;
                        if (mm[f] == 60) begin
                            mm[f] = 0;
                            mh[f] = next_hour(mh[f], f);
                        end
                    end
                end
            end
            pulse     = !set_en && tick_e;
            prev_tick = tick;
            prev_min  = set_min;
            prev_hr   = set_hour;
        end
        e.e24 = pack_time(pulse, mh[0], mm[0], ms[0]);
        e.e12 = pack_time(pulse, mh[1], mm[1], ms[1]);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(string name, logic [20:0] got, logic [20:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d: got pulse=%0b %0d%0d:%0d%0d:%0d%0d need pulse=%0b %0d%0d:%0d%0d:%0d%0d",
                     name, cyc, got[20], got[5:4], got[3:0], got[12:10], got[9:6],
                     got[19:17], got[16:13], want[20], want[5:4], want[3:0],
                     want[12:10], want[9:6], want[19:17], want[16:13]);
        end
    endtask

    // Monitor: compare each DUT's registered outputs just after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dut24", {p24, st24, su24, mt24, mu24, ht24, hu24}, e.e24);
                check("dut12", {p12, st12, su12, mt12, mu12, ht12, hu12}, e.e12);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic tick_once();
        tick = ~tick;
        step();
        step();
    endtask

    task automatic pulse_min();
        set_min = 1'b1; step();
        set_min = 1'b0; step();
    endtask

    task automatic pulse_hr();
        set_hour = 1'b1; step();
        set_hour = 1'b0; step();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b1; step();
        rst = 1'b0; step();
    endtask

    task automatic set_time(int hp, int mp);
        set_en = 1'b1; step();
        repeat (hp) pulse_hr();
        repeat (mp) pulse_min();
        set_en = 1'b0; step();
    endtask

    initial begin
        // 60 tick toggles, one every 4 cycles
        do_reset();
        repeat (60) begin
            tick = ~tick;
            step();
            idle(3);
        end

        // Every hour value through the xx:59:59 rollover in both formats
        for (int hc = 0; hc < 24; hc++) begin
            do_reset();
            set_time(hc, 59);
            repeat (58) tick_once();
            repeat (2) tick_once();
        end

        // Set mode: ticks ignored, minute edges only, held level counts once
        do_reset();
        set_time(10, 20);
        repeat (37) tick_once();
        set_en = 1'b1; tick = ~tick; step();
        repeat (5) tick_once();
        repeat (3) pulse_min();
        set_min = 1'b1; idle(50);
        set_min = 1'b0; step();

        // Minute wrap without hour carry plus simultaneous hour edge
        repeat (35) pulse_min();
        set_min = 1'b1; set_hour = 1'b1; step();
        set_min = 1'b0; set_hour = 1'b0; step();
        set_en = 1'b0; step();
        tick_once();
        // Tick arriving in the same cycle set mode is released
        set_en = 1'b1; step();
        set_en = 1'b0; tick = ~tick; step();
        step();

        // Reset mid-count with tick high, then the first falling tick
        do_reset();
        set_time(5, 30);
        repeat (42) tick_once();
        if (tick == 1'b0) tick_once();
        rst = 1'b1; step();
        rst = 1'b0; step();
        tick = 1'b0; step();
        step();

        // Set buttons in run mode have no effect
        repeat (10) begin
            pulse_hr();
            pulse_min();
        end

        // Randomized traffic
        repeat (4000) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) set_en = ~set_en;
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            set_min  = 1'($urandom_range(0, 1));
            set_hour = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; set_en = 1'b0; set_min = 1'b0; set_hour = 1'b0;
        idle(2);

        repeat (2) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending entries need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
